fifo_wr_arb: RTL and testbench

Two-requester round-robin write arbiter sharing the single write port of the 8-entry FIFO. It sits between two producers and the FIFO's `wr_en`/`din` inputs, and grants the port in bursts of up to `MAX_BURST` beats. It stalls on the FIFO `full` flag without releasing the grant. Each requester sees a per-beat accept strobe, so no data is lost or duplicated.

---
 rtl/fifo_pkg.sv | 47 ++++
 rtl/fifo_arb_ns.sv | 112 +++++++++++
 rtl/fifo_wr_arb.sv | 98 +++++++++
 tb/tb_fifo_wr_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the 8-entry FIFO and its two-requester write arbiter.
//   - fifo_state_t : state encodings of the existing FIFO controller
//   - arb_state_t  : state encodings of the write-port arbiter
//   - helpers      : grant-state selection and burst-limit test
// ---------------------------------------------------------------------------
package fifo_pkg;

    // Existing FIFO controller states (encodings are fixed by the FIFO core).
    typedef enum logic [2:0] {
        INIT     = 3'b000,
        READ     = 3'b001,
        WRITE    = 3'b010,
        RD_ERROR = 3'b011,
        WR_ERROR = 3'b100,
        NO_OP    = 3'b101
    } fifo_state_t;

    // Write-port arbiter states. 2'b11 is unused and recovers to ARB_IDLE.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_G0   = 2'b01,
        ARB_G1   = 2'b10
    } arb_state_t;

    // Width of the per-grant beat counter (MAX_BURST is limited to 1..15).
    localparam int BEAT_CNT_W = 4;

    // Grant state for requester n.
    function automatic arb_state_t grant_of(input logic n);
        arb_state_t g;
        if (n) begin
            g = ARB_G1;
        end else begin
            g = ARB_G0;
        end
        return g;
    endfunction

    // True when accepting one more beat reaches the burst limit.
    function automatic logic burst_done(input logic [BEAT_CNT_W-1:0] cnt,
                                        input logic [BEAT_CNT_W-1:0] max_burst);
        return ((cnt + 4'd1) == max_burst);
    endfunction

endpackage

// File: rtl/fifo_arb_ns.sv
// ---------------------------------------------------------------------------
// fifo_arb_ns
// Combinational next-state logic of the FIFO write arbiter: decides the
// per-beat accept strobes, the release of the current grant and the next
// values of state, tie-break priority and beat counter.
// Ports:
//   state, prio, beat_cnt : current registered arbiter state
//   req0/1, last0/1       : producer request and end-of-burst flags
//   full                  : FIFO full flag (blocks accepts, freezes the grant)
//   acc0/1                : beat accepted from requester 0/1 this cycle
//   state_nxt, prio_nxt, beat_cnt_nxt : values for the next clock edge
// ---------------------------------------------------------------------------
module fifo_arb_ns
    import fifo_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  arb_state_t                  state,
    input  logic                        prio,
    input  logic [BEAT_CNT_W-1:0]       beat_cnt,
    input  logic                        req0,
    input  logic                        req1,
    input  logic                        last0,
    input  logic                        last1,
    input  logic                        full,
    output logic                        acc0,
    output logic                        acc1,
    output arb_state_t                  state_nxt,
    output logic                        prio_nxt,
    output logic [BEAT_CNT_W-1:0]       beat_cnt_nxt
);

    localparam logic [BEAT_CNT_W-1:0] MAX_BURST_C = BEAT_CNT_W'(MAX_BURST);

    logic granted_s;
    logic own_s;
    logic own_req_s;
    logic own_last_s;
    logic oth_req_s;
    logic accept_s;
    logic rel_last_s;
    logic rel_burst_s;
    logic rel_drop_s;
    logic release_s;

    // Fold both grant states onto "owner" / "other" so one set of release
    // rules serves both requesters.
    assign granted_s  = (state == ARB_G0) || (state == ARB_G1);
    assign own_s      = (state == ARB_G1);
    assign own_req_s  = own_s ? req1  : req0;
    assign own_last_s = own_s ? last1 : last0;
    assign oth_req_s  = own_s ? req0  : req1;

    // full gates the accept directly so wr_en can never rise while full=1.
    assign accept_s    = granted_s && own_req_s && !full;
    assign rel_last_s  = accept_s && own_last_s;
    assign rel_burst_s = accept_s && burst_done(beat_cnt, MAX_BURST_C);
    // A dropped request releases even without an accepted beat.
    assign rel_drop_s  = granted_s && !own_req_s;
    assign release_s   = rel_last_s || rel_burst_s || rel_drop_s;

    assign acc0 = accept_s && (state == ARB_G0);
    assign acc1 = accept_s && (state == ARB_G1);

    // Next state, tie-break priority and beat counter.
    always_comb begin
        state_nxt    = state;
        prio_nxt     = prio;
        beat_cnt_nxt = beat_cnt;
        case (state)
            ARB_IDLE: begin
                beat_cnt_nxt = 4'd0;
                if (req0 && req1) begin
                    state_nxt = grant_of(prio);
                end else if (req0) begin
                    state_nxt = ARB_G0;
                end else if (req1) begin
                    state_nxt = ARB_G1;
                end else begin
                    state_nxt = ARB_IDLE;
                end
            end
            ARB_G0, ARB_G1: begin
                if (release_s) begin
                    prio_nxt     = !own_s;
                    beat_cnt_nxt = 4'd0;
                    if (oth_req_s) begin
                        state_nxt = grant_of(!own_s);
                    end else if (own_req_s && rel_burst_s && !rel_last_s) begin
                        // Burst limit alone: the owner keeps going with no bubble.
                        state_nxt = state;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end else if (accept_s) begin
                    state_nxt    = state;
                    beat_cnt_nxt = beat_cnt + 4'd1;
                end else begin
                    // Stalled on full: hold grant and count.
                    state_nxt    = state;
                    beat_cnt_nxt = beat_cnt;
                end
            end
            default: begin
                state_nxt    = ARB_IDLE;
                prio_nxt     = 1'b0;
                beat_cnt_nxt = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
// Two-requester round-robin arbiter for the single write port of the 8-entry
// FIFO. Grants bursts of up to MAX_BURST beats, stalls on full without
// dropping the grant, and hands over between owners with no idle cycle.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   req0/1, din0/1    : producer valid and data
//   last0/1           : final beat of the producer's burst
//   acc0/1            : beat from producer 0/1 accepted this cycle
//   full              : FIFO full flag
//   wr_en, dout       : FIFO write enable and write data
//   owner             : current or most recent grant holder
//   busy              : a grant is active
// ---------------------------------------------------------------------------
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic                  last0,
    input  logic                  last1,
    output logic                  acc0,
    output logic                  acc1,
    input  logic                  full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  owner,
    output logic                  busy
);

    arb_state_t              state_r;
    arb_state_t              state_nxt_s;
    logic                    prio_r;
    logic                    prio_nxt_s;
    logic [BEAT_CNT_W-1:0]   beat_cnt_r;
    logic [BEAT_CNT_W-1:0]   beat_cnt_nxt_s;
    logic                    owner_r;
    logic                    acc0_s;
    logic                    acc1_s;

    fifo_arb_ns #(
        .MAX_BURST (MAX_BURST)
    ) u_ns (
        .state        (state_r),
        .prio         (prio_r),
        .beat_cnt     (beat_cnt_r),
        .req0         (req0),
        .req1         (req1),
        .last0        (last0),
        .last1        (last1),
        .full         (full),
        .acc0         (acc0_s),
        .acc1         (acc1_s),
        .state_nxt    (state_nxt_s),
        .prio_nxt     (prio_nxt_s),
        .beat_cnt_nxt (beat_cnt_nxt_s)
    );

    // Arbiter registers; owner follows the grant state and holds while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ARB_IDLE;
            prio_r     <= 1'b0;
            beat_cnt_r <= 4'd0;
            owner_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            prio_r     <= prio_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
            if (state_nxt_s == ARB_G0) begin
                owner_r <= 1'b0;
            end else if (state_nxt_s == ARB_G1) begin
                owner_r <= 1'b1;
            end else begin
                owner_r <= owner_r;
            end
        end
    end

    // The accept strobes stay combinational on full so a beat can be taken
    // in the same cycle full drops; they depend only on registered state
    // and the current inputs.
    assign acc0  = acc0_s;
    assign acc1  = acc1_s;
    assign wr_en = acc0_s || acc1_s;
    assign dout  = (state_r == ARB_G1) ? din1 : din0;
    assign owner = owner_r;
    assign busy  = (state_r != ARB_IDLE);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arb
// Directed bench for fifo_wr_arb (DATA_WIDTH=32, MAX_BURST=4). Inputs change
// 1 ns after a rising edge, outputs are compared 1 ns later.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arb;

    logic        clk;
    logic        reset;
    logic        req0;
    logic        req1;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        last0;
    logic        last1;
    logic        acc0;
    logic        acc1;
    logic        full;
    logic        wr_en;
    logic [31:0] dout;
    logic        owner;
    logic        busy;

    int errors = 0;
    int checks = 0;

    fifo_wr_arb #(
        .DATA_WIDTH (32),
        .MAX_BURST  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .din0  (din0),
        .din1  (din1),
        .last0 (last0),
        .last1 (last1),
        .acc0  (acc0),
        .acc1  (acc1),
        .full  (full),
        .wr_en (wr_en),
        .dout  (dout),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  own_seq;
        logic        eo;
        logic [31:0] k0;
        logic [31:0] k1;
        int          n_acc0;

        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; din0 = 32'd0; din1 = 32'd0;
        last0 = 1'b0; last1 = 1'b0; full = 1'b0;

        // Reset for two cycles, then idle.
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idle_busy", busy, 1'b0);
            chk("idle_wr_en", wr_en, 1'b0);
            chk("idle_owner", owner, 1'b0);
            tick();
        end

        // Single producer: 0xA0..0xA5, burst limit splits it 4 + 2 with no bubble.
        req0 = 1'b1; din0 = 32'hA0; last0 = 1'b0;
        #1;
        chk("sp_req_cycle_wr_en", wr_en, 1'b0);
        chk("sp_req_cycle_busy", busy, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            din0  = 32'hA0 + 32'(i);
            last0 = (i == 5);
            #1;
            chk("sp_wr_en", wr_en, 1'b1);
            chk("sp_acc0", acc0, 1'b1);
            chk("sp_acc1", acc1, 1'b0);
            chk("sp_dout", dout, 32'hA0 + 32'(i));
            chk("sp_owner", owner, 1'b0);
            tick();
        end
        req0 = 1'b0; last0 = 1'b0;
        #1;
        chk("sp_end_busy", busy, 1'b0);
        chk("sp_end_wr_en", wr_en, 1'b0);
        chk("sp_end_prio", dut.prio_r, 1'b1);
        tick();

        // Tie from reset, 2-beat bursts: owner order 0,0,1,1,0,0,1,1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        own_seq = 8'b1100_1100;
        k0 = 32'd0; k1 = 32'd0;
        req0 = 1'b1; req1 = 1'b1;
        din0 = 32'hB0; din1 = 32'hC0;
        #1;
        chk("tie_first_wr_en", wr_en, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            // Two extra G0 beats after the 8-beat round-robin check.
            eo    = (i < 8) ? own_seq[i] : 1'b0;
            din0  = 32'hB0 + k0; last0 = k0[0];
            din1  = 32'hC0 + k1; last1 = k1[0];
            #1;
            chk("rr_wr_en", wr_en, 1'b1);
            chk("rr_owner", owner, eo);
            chk("rr_acc0", acc0, !eo);
            chk("rr_acc1", acc1, eo);
            chk("rr_dout", dout, eo ? (32'hC0 + k1) : (32'hB0 + k0));
            tick();
            if (eo) k1 = k1 + 32'd1;
            else    k0 = k0 + 32'd1;
        end

        // G1 beat 1 (0xC4), then beat 2 (0xC5) stalled by full for 3 cycles.
        din0 = 32'hB6; last0 = 1'b0;
        din1 = 32'hC4; last1 = 1'b0;
        #1;
        chk("st_b1_acc1", acc1, 1'b1);
        chk("st_b1_dout", dout, 32'hC4);
        tick();
        din1 = 32'hC5; last1 = 1'b1; full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_wr_en", wr_en, 1'b0);
            chk("st_acc1", acc1, 1'b0);
            chk("st_acc0", acc0, 1'b0);
            chk("st_owner", owner, 1'b1);
            chk("st_beat_cnt", dut.beat_cnt_r, 4'd1);
            tick();
        end
        full = 1'b0;
        #1;
        chk("st_release_wr_en", wr_en, 1'b1);
        chk("st_release_acc1", acc1, 1'b1);
        chk("st_release_dout", dout, 32'hC5);
        tick();
        // Now G0 holds the port; both producers stop.
        req0 = 1'b0; req1 = 1'b0; last1 = 1'b0;
        #1;
        chk("st_drop_owner", owner, 1'b0);
        chk("st_drop_wr_en", wr_en, 1'b0);
        tick();
        #1;
        chk("st_idle_busy", busy, 1'b0);
        tick();

        // Reset after two accepted G0 beats.
        req0 = 1'b1; din0 = 32'hD0; last0 = 1'b0;
        #1;
        chk("mr_req_wr_en", wr_en, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            din0 = 32'hD0 + 32'(i);
            #1;
            chk("mr_acc0", acc0, 1'b1);
            chk("mr_dout", dout, 32'hD0 + 32'(i));
            tick();
        end
        din0 = 32'hD2; reset = 1'b1;
        tick();
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_prio", dut.prio_r, 1'b0);
        chk("mr_wr_en", wr_en, 1'b0);
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; din0 = 32'hE0; din1 = 32'hF0;
        last0 = 1'b0; last1 = 1'b0;
        #1;
        chk("mr_tie_idle_wr_en", wr_en, 1'b0);
        tick();
        n_acc0 = 0;
        #1;
        chk("mr_tie_owner", owner, 1'b0);
        chk("mr_tie_acc0", acc0, 1'b1);
        chk("mr_tie_acc1", acc1, 1'b0);
        chk("mr_tie_dout", dout, 32'hE0);
        if (acc0) n_acc0++;
        tick();

        // Early drop of req0 after one beat while req1 waits.
        req0 = 1'b0;
        #1;
        chk("ed_drop_wr_en", wr_en, 1'b0);
        chk("ed_drop_acc0", acc0, 1'b0);
        if (acc0) n_acc0++;
        tick();
        #1;
        chk("ed_g1_owner", owner, 1'b1);
        chk("ed_g1_acc1", acc1, 1'b1);
        chk("ed_g1_acc0", acc0, 1'b0);
        chk("ed_g1_dout", dout, 32'hF0);
        if (acc0) n_acc0++;
        chk("ed_p0_beats", n_acc0, 32'd1);
        tick();
        req1 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
